// File: rtl/bios_port_arbiter_pkg.sv
// Shared types and defaults for the BIOS read-port arbiter.
// Owner encoding is used by both the response tracker and the testbench.
package bios_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF   = 12;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // Request/grant vector bit positions
    localparam int unsigned IDX_F = 0;
    localparam int unsigned IDX_D = 1;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/bios_port_arbiter_if.sv
// Fetch/data requester handshakes plus the BIOS read port, grouped as one bus.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface bios_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              flush;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              bios_en;
    logic [ADDR_W-1:0] bios_addr;
    logic [31:0]       bios_dout;

    modport slave (
        input  f_req, f_addr, flush, d_req, d_addr, bios_dout,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               bios_en, bios_addr
    );

    modport master (
        output f_req, f_addr, flush, d_req, d_addr, bios_dout,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               bios_en, bios_addr
    );
endinterface

// File: rtl/bios_port_arbiter_rr.sv
// Two-input round-robin arbiter: bit 0 = fetch, bit 1 = data.
// Masked requests never win; the last-winner bit only moves on an actual grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);
    logic       r_last_d;
    logic [1:0] w_req;

    assign w_req = i_req & ~i_mask;

    always_comb begin
        o_gnt = w_req;
        if (w_req == 2'b11) begin
            o_gnt = r_last_d ? 2'b01 : 2'b10;
        end
    end

    // Reset to "data won last" so fetch takes the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b1;
        end else if (|o_gnt) begin
            r_last_d <= o_gnt[1];
        end
    end
endmodule

// File: rtl/bios_port_arbiter.sv
// Shares a 1-cycle-latency BIOS read port between fetch and data requesters,
// tracking the single in-flight response and substituting NOPs for flushed fetches.
module bios_port_arbiter
    import bios_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    bios_port_arbiter_if.slave  bus
);
    logic [1:0]        w_req;
    logic [1:0]        w_mask;
    logic [1:0]        w_gnt;
    owner_e            r_owner;
    owner_e            w_owner_nxt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [ADDR_W-1:0] w_addr;

    // Reset masks both requesters so no grant leaks out while rst_n is low
    assign w_req  = {bus.d_req, bus.f_req};
    assign w_mask = {~rst_n, ~rst_n | bus.flush};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (w_req),
        .i_mask (w_mask),
        .o_gnt  (w_gnt)
    );

    always_comb begin
        w_owner_nxt = OWN_NONE;
        w_addr      = r_addr_hold;
        if (w_gnt[IDX_F]) begin
            w_owner_nxt = OWN_FETCH;
            w_addr      = bus.f_addr;
        end else if (w_gnt[IDX_D]) begin
            w_owner_nxt = OWN_DATA;
            w_addr      = bus.d_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_NONE;
            r_addr_hold <= '0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_addr_hold <= w_addr;
        end
    end

    assign bus.f_gnt     = w_gnt[IDX_F];
    assign bus.d_gnt     = w_gnt[IDX_D];
    assign bus.bios_en   = |w_gnt;
    assign bus.bios_addr = w_addr;

    // Flush is sampled in the response cycle, so only that cycle's flush kills data
    always_comb begin
        bus.f_rvalid = (r_owner == OWN_FETCH);
        bus.d_rvalid = (r_owner == OWN_DATA);
        bus.f_rdata  = '0;
        bus.d_rdata  = '0;
        if (bus.f_rvalid) begin
            bus.f_rdata = bus.flush ? NOP_INST : bus.bios_dout;
        end
        if (bus.d_rvalid) begin
            bus.d_rdata = bus.bios_dout;
        end
    end
endmodule

// File: tb/tb_bios_port_arbiter.sv
// Directed vector table, reset/contention sequences and a random run against
// a behavioural model of the arbiter with a synchronous-read BIOS memory.
module tb_bios_port_arbiter;
    localparam int unsigned AW  = 12;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    bios_port_arbiter_if #(.ADDR_W(AW)) bus ();

    bios_port_arbiter #(.ADDR_W(AW), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {8'h5A, 8'h00, a, 4'h7};
    endfunction

    // BIOS memory: data valid the cycle after enable
    always @(posedge clk) begin
        bus.bios_dout <= bus.bios_en ? mem_word(bus.bios_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic dr,
                         input logic [AW-1:0] da, input logic fl);
        bus.f_req  = fr;
        bus.f_addr = fa;
        bus.d_req  = dr;
        bus.d_addr = da;
        bus.flush  = fl;
    endtask

    task automatic chk_all(input string tag, input logic efg, input logic edg,
                           input logic [AW-1:0] ea, input logic efv, input logic [31:0] efd,
                           input logic edv, input logic [31:0] edd);
        chk({tag, ".f_gnt"},     32'(bus.f_gnt),     32'(efg));
        chk({tag, ".d_gnt"},     32'(bus.d_gnt),     32'(edg));
        chk({tag, ".bios_en"},   32'(bus.bios_en),   32'(efg | edg));
        chk({tag, ".bios_addr"}, 32'(bus.bios_addr), 32'(ea));
        chk({tag, ".f_rvalid"},  32'(bus.f_rvalid),  32'(efv));
        chk({tag, ".f_rdata"},   bus.f_rdata,        efd);
        chk({tag, ".d_rvalid"},  32'(bus.d_rvalid),  32'(edv));
        chk({tag, ".d_rdata"},   bus.d_rdata,        edd);
    endtask

    typedef struct {
        logic fr; logic [AW-1:0] fa; logic dr; logic [AW-1:0] da; logic fl;
        logic efg; logic edg; logic [AW-1:0] ea;
        logic efv; logic [31:0] efd; logic edv; logic [31:0] edd;
    } vec_t;

    vec_t vt[14];

    // Random-run model state
    logic          m_last_d;
    int            m_owner;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_raddr;

    initial begin
        vt[0]  = '{1'b1, 12'h010, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h010, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1, mem_word(12'h010), 1'b0, 32'h0};
        vt[2]  = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b0, 1'b0, 1'b1, 12'h200, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b0, 1'b1, 1'b0, 12'h100, 1'b0, 32'h0, 1'b1, mem_word(12'h200)};
        vt[4]  = '{1'b1, 12'h100, 1'b1, 12'h200, 1'b0, 1'b0, 1'b1, 12'h200, 1'b1, mem_word(12'h100), 1'b0, 32'h0};
        vt[5]  = '{1'b0, 12'h000, 1'b1, 12'h300, 1'b0, 1'b0, 1'b1, 12'h300, 1'b0, 32'h0, 1'b1, mem_word(12'h200)};
        vt[6]  = '{1'b1, 12'h020, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h020, 1'b0, 32'h0, 1'b1, mem_word(12'h300)};
        vt[7]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h020, 1'b1, NOP, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 12'h040, 1'b1, 12'h050, 1'b1, 1'b0, 1'b1, 12'h050, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h050, 1'b0, 32'h0, 1'b1, mem_word(12'h050)};
        vt[10] = '{1'b1, 12'h040, 1'b1, 12'h060, 1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 32'h0, 1'b0, 32'h0};
        vt[11] = '{1'b0, 12'h000, 1'b1, 12'h070, 1'b1, 1'b0, 1'b1, 12'h070, 1'b1, NOP, 1'b0, 32'h0};
        vt[12] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h070, 1'b0, 32'h0, 1'b1, mem_word(12'h070)};
        vt[13] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h070, 1'b0, 32'h0, 1'b0, 32'h0};

        // Reset with both requesters active: nothing may be granted
        rst_n = 1'b0;
        drive(1'b1, 12'h3AB, 1'b1, 12'h3CD, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_all("post_reset", 1'b0, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vt[i].fr, vt[i].fa, vt[i].dr, vt[i].da, vt[i].fl);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].efg, vt[i].edg, vt[i].ea,
                    vt[i].efv, vt[i].efd, vt[i].edv, vt[i].edd);
        end

        // Reset while a fetch response is in flight
        @(negedge clk);
        drive(1'b1, 12'h0AA, 1'b0, 12'h000, 1'b0);
        #1;
        chk("midrst.f_gnt", 32'(bus.f_gnt), 32'd1);
        @(negedge clk);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("midrst.in", 1'b0, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("midrst.rel", 1'b0, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 32'h0);

        // Contention right after reset: F, D, F, D, then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(i < 4, 12'h1F0, i < 4, 12'h2E0, 1'b0);
            #1;
            chk_all($sformatf("cont%0d", i),
                    (i < 4) && (i % 2 == 0), (i < 4) && (i % 2 == 1),
                    (i == 4) ? 12'h2E0 : ((i % 2 == 0) ? 12'h1F0 : 12'h2E0),
                    (i > 0) && ((i - 1) % 2 == 0), ((i > 0) && ((i - 1) % 2 == 0)) ? mem_word(12'h1F0) : 32'h0,
                    (i > 0) && ((i - 1) % 2 == 1), ((i > 0) && ((i - 1) % 2 == 1)) ? mem_word(12'h2E0) : 32'h0);
        end

        // Random run against a behavioural model
        m_last_d = 1'b1;
        m_owner  = 0;
        m_addr   = 12'h2E0;
        m_raddr  = 12'h000;
        for (int c = 0; c < 10000; c++) begin
            logic fr, dr, fl, ef, ed;
            logic [AW-1:0] fa, da, ea;
            @(negedge clk);
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 3) == 0);
            fa = AW'($urandom);
            da = AW'($urandom);
            drive(fr, fa, dr, da, fl);
            #1;
            ef = fr && !fl && !(dr && !m_last_d);
            ed = dr && !ef;
            ea = ef ? fa : (ed ? da : m_addr);
            chk_all($sformatf("rnd%0d", c), ef, ed, ea,
                    m_owner == 1, (m_owner == 1) ? (fl ? NOP : mem_word(m_raddr)) : 32'h0,
                    m_owner == 2, (m_owner == 2) ? mem_word(m_raddr) : 32'h0);
            m_owner = ef ? 1 : (ed ? 2 : 0);
            m_raddr = ea;
            m_addr  = ea;
            if (ef || ed) m_last_d = ed;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
